// File: rtl/instr_fetch_unit.sv
// picoMIPS fetch stage: PC, program memory address, instruction register, branch flush.
// Define FETCH_HALT_EN to stop fetching on a HALT opcode.
module instr_fetch_unit #(
   parameter int                       ADDR_WIDTH   = 6,
   parameter int                       INSTR_WIDTH  = 24,
   parameter int                       OPCODE_WIDTH = 6,
   parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR    = '0,
   parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE  = 6'h3F
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic [ADDR_WIDTH-1:0]   pm_addr,
   input  logic [INSTR_WIDTH-1:0]  pm_instr,
   input  logic                    stall,
   input  logic                    branch_en,
   input  logic                    branch_rel,
   input  logic [ADDR_WIDTH-1:0]   branch_target,
   output logic [INSTR_WIDTH-1:0]  ir,
   output logic [ADDR_WIDTH-1:0]   ir_pc,
   output logic                    ir_valid,
   output logic                    halted
);

   typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH, ST_HALT} state_t;

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
   logic [ADDR_WIDTH-1:0]    ir_pc_q, ir_pc_d;
   logic                     ir_valid_q, ir_valid_d;
   logic [ADDR_WIDTH-1:0]    target;

   // Relative offset is two's complement; the natural-width add wraps modulo 2^ADDR_WIDTH.
   assign target = branch_rel ? (ir_pc_q + branch_target) : branch_target;

`ifdef FETCH_HALT_EN
   logic halted_q, halted_d;
   logic is_halt;
   assign is_halt = (ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
`ifdef FETCH_HALT_EN
      halted_d   = halted_q;
`endif
      if (!stall) begin
         case (state_q)
            ST_FILL, ST_FLUSH: begin
               ir_d       = pm_instr;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               pc_d       = pc_q + 1'b1;
               state_d    = ST_RUN;
            end
            ST_RUN: begin
               if (branch_en && ir_valid_q) begin
                  pc_d       = target;
                  ir_d       = NOP_INSTR;
                  ir_valid_d = 1'b0;
                  state_d    = ST_FLUSH;
               end
`ifdef FETCH_HALT_EN
               else if (ir_valid_q && is_halt) begin
                  // PC already points past the HALT word and stays there.
                  ir_valid_d = 1'b0;
                  halted_d   = 1'b1;
                  state_d    = ST_HALT;
               end
`endif
               else begin
                  ir_d       = pm_instr;
                  ir_pc_d    = pc_q;
                  ir_valid_d = 1'b1;
                  pc_d       = pc_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FILL;
         pc_q       <= '0;
         ir_q       <= NOP_INSTR;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
         halted_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
`ifdef FETCH_HALT_EN
         halted_q   <= halted_d;
`endif
      end
   end

   assign pm_addr  = pc_q;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;
`ifdef FETCH_HALT_EN
   assign halted   = halted_q;
`else
   assign halted   = 1'b0;
`endif

endmodule
